// File: rtl/blink_monitor_pkg.sv
// Shared types for the blink monitor: the lock-tracking state encoding.
package blink_pkg;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} blink_state_t;

endpackage

// File: rtl/blink_monitor_if.sv
// Bundle of the monitored line, the fault-clear strobe and the monitor's reports.
interface blink_monitor_if #(
  parameter int CW = 4
);

  logic          sig_in;
  logic          fault_clr;
  logic          locked;
  logic          meas_valid;
  logic [CW-1:0] meas_half;
  logic          fault_fast;
  logic          fault_stuck;

  // master drives the line under test; slave is the monitor itself
  modport master (
    output sig_in, fault_clr,
    input  locked, meas_valid, meas_half, fault_fast, fault_stuck
  );

  modport slave (
    input  sig_in, fault_clr,
    output locked, meas_valid, meas_half, fault_fast, fault_stuck
  );

endinterface

// File: rtl/blink_monitor_sync_edge.sv
// Brings the asynchronous line into the clk domain and flags either-polarity edges,
// ignoring the first cycles after reset so a line already high is not seen as an edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_det
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] mask_cnt;

  // prev keeps following sync2 while masked, so the mask ends with no stale difference
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      mask_cnt <= 2'd0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      if (mask_cnt != 2'd3)
        mask_cnt <= mask_cnt + 2'd1;
    end
  end

  assign edge_det = (sync2 ^ prev) && (mask_cnt == 2'd3);

endmodule

// File: rtl/blink_monitor.sv
// Measures edge-to-edge intervals of a heartbeat line, locks onto a run of in-range
// half-periods and raises sticky flags when a locked line goes too fast or stops.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CLK_FREQ_KHz = 50000,
  parameter int LED_FREQ_Hz  = 1,
  parameter int TOL_PCT      = 10,
  parameter int LOCK_EDGES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  blink_monitor_if.slave  bus
);

  localparam int HALF_PERIOD = (CLK_FREQ_KHz * 1000) / (LED_FREQ_Hz * 2);
  localparam int TOL         = HALF_PERIOD * TOL_PCT / 100;
  localparam int MIN_HP      = HALF_PERIOD - TOL;
  localparam int MAX_HP      = HALF_PERIOD + TOL;
  localparam int CW          = $clog2(MAX_HP + 2);
  localparam int GW          = $clog2(LOCK_EDGES + 1);

  localparam logic [CW-1:0] MIN_C  = CW'(MIN_HP);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_HP);
  localparam logic [GW-1:0] LOCK_C = GW'(LOCK_EDGES);

  blink_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n, meas, meas_half_q;
  logic [GW-1:0] good, good_n, good_inc;
  logic          edge_det, timeout, in_range;
  logic          mv_n, set_fast, set_stuck;
  logic          meas_valid_q, fault_fast_q, fault_stuck_q;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .din      (bus.sig_in),
    .edge_det (edge_det)
  );

  // a saturated counter means the interval already exceeds MAX_HP, so timeout wins over any edge
  assign timeout  = (cnt == MAX_C);
  assign meas     = cnt + CW'(1);
  assign in_range = (meas >= MIN_C) && (meas <= MAX_C);
  assign good_inc = good + GW'(1);
  assign cnt_n    = edge_det ? '0 : (timeout ? cnt : cnt + CW'(1));

  always_comb begin
    state_n   = state;
    good_n    = good;
    mv_n      = 1'b0;
    set_fast  = 1'b0;
    set_stuck = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
      end
      ACQUIRE: begin
        if (timeout) begin
          state_n = IDLE;
          good_n  = '0;
        end else if (edge_det) begin
          mv_n = 1'b1;
          if (in_range) begin
            good_n = good_inc;
            if (good_inc == LOCK_C)
              state_n = LOCKED;
          end else begin
            good_n = '0;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          set_stuck = 1'b1;
          state_n   = FAULT;
        end else if (edge_det) begin
          mv_n = 1'b1;
          if (!in_range) begin
            set_fast = 1'b1;
            state_n  = FAULT;
          end
        end
      end
      FAULT: begin
        if (edge_det) begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      good          <= '0;
      meas_valid_q  <= 1'b0;
      meas_half_q   <= '0;
      fault_fast_q  <= 1'b0;
      fault_stuck_q <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      good          <= good_n;
      meas_valid_q  <= mv_n;
      if (mv_n)
        meas_half_q <= meas;
      fault_fast_q  <= set_fast  | (fault_fast_q  & ~bus.fault_clr);
      fault_stuck_q <= set_stuck | (fault_stuck_q & ~bus.fault_clr);
    end
  end

  assign bus.locked      = (state == LOCKED);
  assign bus.meas_valid  = meas_valid_q;
  assign bus.meas_half   = meas_half_q;
  assign bus.fault_fast  = fault_fast_q;
  assign bus.fault_stuck = fault_stuck_q;

endmodule
